// File: rtl/trace_memory_ctrl.sv
// trace_memory_ctrl: owns the trace RAM; circular trace buffer with a post-trigger
// delay and freeze in trace mode, a request-drained FIFO in stream mode.
module trace_memory_ctrl #(
    parameter int TRB_WIDTH  = 32,
    parameter int TRB_DEPTH  = 64,
    parameter int DELAY_BITS = 16,
    localparam int AW = $clog2(TRB_DEPTH)
) (
    input  logic                  FPGA_CLK_I,
    input  logic                  RST_NI,
    input  logic                  EN_I,
    input  logic                  MODE_I,
    input  logic [DELAY_BITS-1:0] DELAY_I,
    input  logic                  STORE_I,
    input  logic [TRB_WIDTH-1:0]  DATA_I,
    input  logic                  TRG_EVENT_I,
    input  logic                  REQ_I,
    output logic [TRB_WIDTH-1:0]  DATA_O,
    output logic                  LOAD_O,
    output logic                  TRG_DELAYED_O,
    output logic [AW-1:0]         TRG_ADDR_O,
    input  logic                  SYS_WE_I,
    input  logic [TRB_WIDTH-1:0]  SYS_WDATA_I,
    output logic                  SYS_FULL_O,
    output logic [AW:0]           LEVEL_O,
    input  logic [AW-1:0]         SYS_RADDR_I,
    output logic [TRB_WIDTH-1:0]  SYS_RDATA_O
);
    localparam logic [1:0] ARMED = 2'd0, DELAY = 2'd1, FROZEN = 2'd2;
    localparam logic [AW:0] FULL = (AW+1)'(TRB_DEPTH);
    logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];
    logic [1:0] state;
    logic mode_q, pend;
    logic [AW-1:0] wr_ptr, rd_ptr, cnt, cnt_ld, cur_cnt;
    logic [AW:0] count;
    logic flush, store, trig, pop_req, pop, push, we, load;
    always_comb begin
        flush   = MODE_I != mode_q;
        store   = EN_I && STORE_I && !flush && !mode_q;
        trig    = !flush && !mode_q && state == ARMED && TRG_EVENT_I;
        // clamp so the post-trigger window never wraps onto the trigger word
        cnt_ld  = 32'(DELAY_I) > TRB_DEPTH - 1 ? AW'(TRB_DEPTH - 1) : AW'(DELAY_I);
        cur_cnt = trig ? cnt_ld : cnt;
        pop_req = EN_I && mode_q && !flush && (pend || REQ_I);
        pop     = pop_req && count != '0;
        push    = EN_I && mode_q && !flush && SYS_WE_I && (count != FULL || pop);
        we      = mode_q ? push : store && state != FROZEN;
        load    = mode_q ? pop : store;
    end
    assign TRG_DELAYED_O = state == FROZEN;
    assign SYS_FULL_O    = count == FULL;
    assign LEVEL_O       = count;
    always_ff @(posedge FPGA_CLK_I)
        if (we) mem[wr_ptr] <= mode_q ? SYS_WDATA_I : DATA_I;
    always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            mode_q      <= 1'b0;
            LOAD_O      <= 1'b0;
            DATA_O      <= '0;
            SYS_RDATA_O <= '0;
            TRG_ADDR_O  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pend        <= 1'b0;
            cnt         <= '0;
            state       <= ARMED;
        end else begin
            mode_q      <= MODE_I;
            LOAD_O      <= load;
            SYS_RDATA_O <= mem[SYS_RADDR_I];
            if (load) DATA_O <= mem[mode_q ? rd_ptr : wr_ptr];
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                pend       <= 1'b0;
                cnt        <= '0;
                state      <= ARMED;
                TRG_ADDR_O <= '0;
            end else begin
                if (we) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
                if (EN_I && mode_q) pend <= pop_req && !pop;
                if (trig) begin
                    TRG_ADDR_O <= wr_ptr;
                    state      <= DELAY;
                    cnt        <= cnt_ld;
                end
                if ((trig || state == DELAY) && store) begin
                    if (cur_cnt == '0) state <= FROZEN;
                    else cnt <= cur_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_memory_ctrl.sv
// tb_trace_memory_ctrl: directed checks of trace freeze/wrap, stream FIFO,
// mode flush and async reset.
module tb_trace_memory_ctrl;
    logic clk = 0, rst_n = 0, en = 0, mode = 0, store = 0, trg = 0, req = 0, sys_we = 0;
    logic [15:0] delay = 0;
    logic [31:0] data = 0, wdata = 0;
    logic [5:0] raddr = 0;
    logic [31:0] dout, rdata, dout4, rdata4;
    logic load, trg_dly, full, load4, trg_dly4, full4;
    logic [5:0] trg_addr;
    logic [1:0] trg_addr4;
    logic [6:0] level;
    logic [2:0] level4;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    trace_memory_ctrl u_dut (
        .FPGA_CLK_I(clk), .RST_NI(rst_n), .EN_I(en), .MODE_I(mode), .DELAY_I(delay),
        .STORE_I(store), .DATA_I(data), .TRG_EVENT_I(trg), .REQ_I(req),
        .DATA_O(dout), .LOAD_O(load), .TRG_DELAYED_O(trg_dly), .TRG_ADDR_O(trg_addr),
        .SYS_WE_I(sys_we), .SYS_WDATA_I(wdata), .SYS_FULL_O(full), .LEVEL_O(level),
        .SYS_RADDR_I(raddr), .SYS_RDATA_O(rdata)
    );

    trace_memory_ctrl #(.TRB_DEPTH(4)) u_dut4 (
        .FPGA_CLK_I(clk), .RST_NI(rst_n), .EN_I(en), .MODE_I(mode), .DELAY_I(delay),
        .STORE_I(store), .DATA_I(data), .TRG_EVENT_I(trg), .REQ_I(req),
        .DATA_O(dout4), .LOAD_O(load4), .TRG_DELAYED_O(trg_dly4), .TRG_ADDR_O(trg_addr4),
        .SYS_WE_I(sys_we), .SYS_WDATA_I(wdata), .SYS_FULL_O(full4), .LEVEL_O(level4),
        .SYS_RADDR_I(raddr[1:0]), .SYS_RDATA_O(rdata4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] v);
        store = 1; data = v;
        tick();
        store = 0;
    endtask

    task automatic do_push(input logic [31:0] v);
        sys_we = 1; wdata = v;
        tick();
        sys_we = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    initial begin
        tick(); tick();
        check("rst_load", load, 0);
        check("rst_data", dout, 0);
        check("rst_trg_dly", trg_dly, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        rst_n = 1; en = 1;

        // wrap on the 4-deep instance
        for (int i = 0; i < 5; i++) do_store(32'hA + i);
        raddr = 0; tick(); tick();
        check("wrap_mem0", rdata4, 32'hE);
        raddr = 1; tick(); tick();
        check("wrap_mem1", rdata4, 32'hB);
        do_store(32'hF);
        check("wrap_load", load4, 1);
        check("wrap_data", dout4, 32'hB);

        // prefill RAM with known values, then restart from reset
        do_reset();
        for (int i = 0; i < 10; i++) do_store(32'h100 + i);
        do_reset();

        // trigger with DELAY_I = 2
        for (int i = 0; i < 4; i++) do_store(i);
        delay = 2; trg = 1;
        tick();
        check("t1_trg_addr", trg_addr, 4);
        check("t1_dly_armed", trg_dly, 0);
        do_store(4);
        check("t1_dly_s4", trg_dly, 0);
        do_store(5);
        check("t1_dly_s5", trg_dly, 0);
        do_store(6);
        check("t1_dly_s6", trg_dly, 1);
        do_store(7);
        check("t1_frozen_load", load, 1);
        check("t1_frozen_data", dout, 32'h107);
        do_store(8); do_store(9);
        raddr = 7; tick(); tick();
        check("t1_mem7_old", rdata, 32'h107);
        raddr = 6; tick(); tick();
        check("t1_mem6", rdata, 6);
        raddr = 4; tick(); tick();
        check("t1_mem4", rdata, 4);

        // mode toggle while frozen
        mode = 1;
        tick();
        check("flush_trg_dly", trg_dly, 0);
        check("flush_level", level, 0);
        check("flush_trg_addr", trg_addr, 0);
        mode = 0; trg = 0;
        tick();

        // long delay is clamped to TRB_DEPTH-1
        for (int i = 0; i < 3; i++) do_store(32'h200 + i);
        delay = 1000; trg = 1;
        do_store(32'h5A5A);
        check("t3_trg_addr", trg_addr, 3);
        for (int i = 1; i < 63; i++) do_store(32'h300 + i);
        check("t3_dly_63", trg_dly, 0);
        do_store(32'h33F);
        check("t3_dly_64", trg_dly, 1);
        raddr = 3; tick(); tick();
        check("t3_trig_word", rdata, 32'h5A5A);
        raddr = 2; tick(); tick();
        check("t3_last_word", rdata, 32'h33F);
        trg = 0;

        // stream: request on empty FIFO, served after the first push
        mode = 1;
        tick();
        req = 1; tick(); req = 0;
        check("s_empty_load", load, 0);
        tick(); tick();
        check("s_empty_load2", load, 0);
        do_push(32'hA5A5A5A5);
        check("s_push_load", load, 0);
        check("s_push_level", level, 1);
        tick();
        check("s_pop_load", load, 1);
        check("s_pop_data", dout, 32'hA5A5A5A5);
        check("s_pop_level", level, 0);
        tick();
        check("s_pop_once", load, 0);

        // stream full
        for (int i = 0; i < 64; i++) do_push(32'h400 + i);
        check("s_full", full, 1);
        check("s_full_level", level, 64);
        do_push(32'hDEAD);
        check("s_drop_level", level, 64);
        check("s_drop_full", full, 1);
        req = 1; sys_we = 1; wdata = 32'hBEEF;
        tick();
        req = 0; sys_we = 0;
        check("s_pp_load", load, 1);
        check("s_pp_data", dout, 32'h400);
        check("s_pp_level", level, 64);
        tick();
        check("s_pp_once", load, 0);
        en = 0; req = 1;
        tick();
        check("s_en_load", load, 0);
        check("s_en_level", level, 64);
        req = 0; en = 1;
        req = 1; tick(); req = 0;
        check("s_next_data", dout, 32'h401);
        check("s_next_level", level, 63);

        // async reset mid-stream
        req = 1; tick(); req = 0;
        check("ar_load_before", load, 1);
        #2 rst_n = 0;
        #1;
        check("ar_load", load, 0);
        check("ar_level", level, 0);
        #2 rst_n = 1;
        tick();
        req = 1; tick(); req = 0;
        #2 rst_n = 0;
        #2 rst_n = 1;
        tick();
        do_push(32'h77);
        check("ar_pend_load", load, 0);
        tick();
        check("ar_pend_load2", load, 0);
        check("ar_pend_level", level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
